mii_checker_fsm: RTL and testbench
==================================

Name: mii_checker_fsm

Overview:
- Passive checker on a 64-bit XGMII-style MII receive stream: 8 byte lanes per clock, one control bit per lane.
- Tracks idle, start, data and terminate sequencing with a 3-state FSM, measures frame length, and flags protocol violations.
- Sits on the receive path after the PCS decoder as a monitor; it does not modify the stream.

Parameters:
- MIN_LEN, 64, minimum legal frame payload length in bytes (used only with the optional feature).
- MAX_LEN, 1518, maximum legal frame payload length in bytes (used only with the optional feature).
- CNT_W, 32, width of the frame, error and length counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Despite the name, it is synchronous and active-high: reset is applied on a clk edge while rst_n=1.
- data_in  in  64  lane i = data_in[8i+7:8i]; lane 0 is the first byte on the wire.
- ctrl_in  in  8  ctrl_in[i]=1 means lane i carries a control character.
- state  out  2  FSM state: 0=IDLE, 1=DATA, 2=ERROR.
- frame_ok  out  1  one-cycle pulse when a frame ends correctly.
- frame_err  out  1  one-cycle pulse on any protocol violation.
- frame_len  out  16  data byte count of the last frame, valid when frame_ok pulses.
- ok_count  out  CNT_W  number of good frames.
- err_count  out  CNT_W  number of violations.

Behaviour:
- Control codes: IDLE=0x07, START=0xFB, TERM=0xFD.
- Word classes:
  - idle word: ctrl=0xFF and all lanes 0x07.
  - start word: ctrl=0x01, lane0=0xFB, lanes 1-6=0x55, lane 7 = 0x55 or 0xD5.
  - data word: ctrl=0x00.
  - terminate word at lane k (0..7): ctrl=(0xFF<<k)&0xFF, lane k=0xFD, all lanes above k =0x07; lanes below k are data.
- All outputs are registered. On reset: state=IDLE, frame_ok=0, frame_err=0, frame_len=0, both counters=0, internal byte counter=0.
- Each word is evaluated in the cycle it is sampled. Pulses and counter updates appear one clk after that word.
- IDLE state:
  - idle word -> stay in IDLE.
  - start word -> go to DATA; byte counter=0. Preamble bytes are not counted.
  - any other word -> frame_err, err_count+1, go to ERROR.
- DATA state:
  - data word -> byte counter +8, stay in DATA.
  - terminate at lane k -> frame_len = counter+k, frame_ok, ok_count+1, go to IDLE.
  - start word, idle word, or any malformed control word -> frame_err, err_count+1, go to ERROR.
- ERROR state:
  - stay until an idle word arrives, then go to IDLE.
  - a start word seen in ERROR is ignored; an idle word must come first.
  - no further err_count increments while in ERROR.
- Byte counter saturates at 0xFFFF. ok_count and err_count saturate at all-ones.
- Reset asserted mid-frame: return to IDLE immediately; the partial frame is not counted.
- Encoding 3 of state is never used; if reached, the FSM goes to IDLE.

Optional Feature:
- Macro: MII_CHECKER_LEN_CHECK_EN.
- Defined: a terminate word is accepted only if MIN_LEN <= frame_len <= MAX_LEN. Otherwise it raises frame_err (not frame_ok), increments err_count, and goes to IDLE (not ERROR); frame_len still updates.
- Undefined: no length limits apply; MIN_LEN and MAX_LEN are unused.

Test Plan:
- Reset, then 10 idle words (0x0707070707070707, ctrl 0xFF) -> state=IDLE, no pulses, counters 0.
- Start word 0x55555555555555FB/0x01, 20 words 0x1111111111111111/0x00, then 0x07070707FD000000/0xF8 -> frame_ok one cycle later, frame_len=163, ok_count=1, err_count=0.
- Start word, 2 data words, then idle word -> frame_err, err_count=1, state=ERROR; the next idle word -> IDLE.
- Terminate at lane 0 (0x07070707070707FD/0xFF) after 8 data words -> frame_len=64, frame_ok.
- Second start word inside a frame -> frame_err, ERROR. Then start, idle, start, one data word, terminate at lane 0 -> ERROR ignores the first start; idle returns to IDLE; then frame_ok with frame_len=8.
- With MII_CHECKER_LEN_CHECK_EN defined: frame of 1 data word + terminate at lane 0 (frame_len=8) -> frame_err, err_count+1, state IDLE. Frame of 163 bytes -> frame_ok.

Source files
------------

// File: rtl/mii_checker_fsm.sv
// Passive checker for a 64-bit XGMII-style receive stream: classifies each word,
// tracks frame sequencing, measures frame length and counts good frames and violations.
// Optional build macro MII_CHECKER_LEN_CHECK_EN rejects frames outside MIN_LEN..MAX_LEN bytes.
module mii_checker_fsm #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      data_in,
  input  logic [7:0]       ctrl_in,
  output logic [1:0]       state,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [15:0]      frame_len,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [7:0]  C_IDLE  = 8'h07;
  localparam logic [7:0]  C_START = 8'hFB;
  localparam logic [7:0]  C_TERM  = 8'hFD;
  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifndef MII_CHECKER_LEN_CHECK_EN
  logic unused_len_cfg;
  assign unused_len_cfg = ^{MIN_L, MAX_L};
`endif

  state_t           state_q, state_d;
  logic [15:0]      byte_cnt, cnt_d, len_d, term_len;
  logic             ok_d, err_d;
  logic [CNT_W-1:0] okc_d, errc_d;

  logic       is_idle, is_start, is_data, term_hit;
  logic [2:0] term_lane;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Word classification; at most one terminate lane can match since each k has a unique ctrl pattern.
  always_comb begin
    logic lane_ok;
    is_idle  = (ctrl_in == 8'hFF) && (data_in == {8{C_IDLE}});
    is_start = (ctrl_in == 8'h01) && (data_in[7:0] == C_START) &&
               (data_in[55:8] == {6{8'h55}}) &&
               ((data_in[63:56] == 8'h55) || (data_in[63:56] == 8'hD5));
    is_data  = (ctrl_in == 8'h00);
    term_hit  = 1'b0;
    term_lane = 3'd0;
    for (int k = 0; k < 8; k++) begin
      lane_ok = (ctrl_in == 8'(8'hFF << k)) && (data_in[8*k +: 8] == C_TERM);
      for (int j = 0; j < 8; j++) begin
        if (j > k && data_in[8*j +: 8] != C_IDLE) lane_ok = 1'b0;
      end
      if (lane_ok) begin
        term_hit  = 1'b1;
        term_lane = 3'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    len_d    = frame_len;
    cnt_d    = byte_cnt;
    okc_d    = ok_count;
    errc_d   = err_count;
    term_len = sat_add16(byte_cnt, {1'b0, term_lane});
    case (state_q)
      S_IDLE: begin
        if (!is_idle) begin
          if (is_start) begin
            state_d = S_DATA;
            cnt_d   = 16'd0;
          end else begin
            err_d   = 1'b1;
            errc_d  = sat_inc(err_count);
            state_d = S_ERROR;
          end
        end
      end
      S_DATA: begin
        if (is_data) begin
          cnt_d = sat_add16(byte_cnt, 4'd8);
        end else if (term_hit) begin
          len_d   = term_len;
          state_d = S_IDLE;
`ifdef MII_CHECKER_LEN_CHECK_EN
          // Out-of-range frames are still well delimited, so recover straight to IDLE.
          if (term_len >= MIN_L && term_len <= MAX_L) begin
            ok_d  = 1'b1;
            okc_d = sat_inc(ok_count);
          end else begin
            err_d  = 1'b1;
            errc_d = sat_inc(err_count);
          end
`else
          ok_d  = 1'b1;
          okc_d = sat_inc(ok_count);
`endif
        end else begin
          err_d   = 1'b1;
          errc_d  = sat_inc(err_count);
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        if (is_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      frame_len <= 16'd0;
      ok_count  <= '0;
      err_count <= '0;
      byte_cnt  <= 16'd0;
    end else begin
      state_q   <= state_d;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      frame_len <= len_d;
      ok_count  <= okc_d;
      err_count <= errc_d;
      byte_cnt  <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mii_checker_fsm.sv
// Scoreboard bench for mii_checker_fsm: directed words push expected pulses,
// an independent monitor pops and compares whenever frame_ok or frame_err fires.
module tb_mii_checker_fsm;

  localparam int CNT_W = 32;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'h55555555555555FB;
  localparam logic [63:0] STARTD5 = 64'hD5555555555555FB;
  localparam logic [63:0] DATA_W  = 64'h1111111111111111;
  localparam logic [63:0] TERM3_W = 64'h07070707FD000000;
  localparam logic [63:0] TERM0_W = 64'h07070707070707FD;
  localparam logic [63:0] TERM7_W = 64'hFD22222222222222;
  localparam logic [63:0] BADT_W  = 64'h07070755FD000000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [63:0]      data_in;
  logic [7:0]       ctrl_in;
  logic [1:0]       state;
  logic             frame_ok, frame_err;
  logic [15:0]      frame_len;
  logic [CNT_W-1:0] ok_count, err_count;

  mii_checker_fsm #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ctrl_in(ctrl_in),
    .state(state), .frame_ok(frame_ok), .frame_err(frame_err),
    .frame_len(frame_len), .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          ok;
    logic [15:0] len;
    logic [31:0] okc;
    logic [31:0] errc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] m_okc = 0;
  logic [31:0] m_errc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] c);
    data_in = d;
    ctrl_in = c;
    @(posedge clk);
    #1;
  endtask

  // Record the pulse the next applied word must produce one clock later.
  task automatic expectPulse(input bit ok, input logic [15:0] len);
    exp_t e;
    if (ok) m_okc++; else m_errc++;
    e.cyc  = cyc + 1;
    e.ok   = ok;
    e.len  = len;
    e.okc  = m_okc;
    e.errc = m_errc;
    sb.push_back(e);
  endtask

  function automatic bit lenOk(input int len);
`ifdef MII_CHECKER_LEN_CHECK_EN
    return (len >= 64) && (len <= 1518);
`else
    return (len >= 0);
`endif
  endfunction

  task automatic sendFrame(input int ndata, input logic [63:0] tw, input logic [7:0] tc,
                           input int exp_len, input string name);
    applyStimulus(START_W, 8'h01);
    for (int i = 0; i < ndata; i++) applyStimulus(DATA_W, 8'h00);
    expectPulse(lenOk(exp_len), 16'(exp_len));
    applyStimulus(tw, tc);
    checkOutput({name, "_state"}, 32'(state), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checkOutput("missed_pulse_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (frame_ok || frame_err) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", {30'd0, frame_ok, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("pulse_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("frame_ok", 32'(frame_ok), 32'(e.ok));
        checkOutput("frame_err", 32'(frame_err), 32'(!e.ok));
        if (e.ok) checkOutput("frame_len", 32'(frame_len), 32'(e.len));
        checkOutput("ok_count", ok_count, e.okc);
        checkOutput("err_count", err_count, e.errc);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    applyStimulus(IDLE_W, 8'hFF);
    applyStimulus(IDLE_W, 8'hFF);
    rst_n = 1'b0;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_ok", 32'(frame_ok), 32'd0);
    checkOutput("rst_err", 32'(frame_err), 32'd0);
    checkOutput("rst_len", 32'(frame_len), 32'd0);
    checkOutput("rst_okc", ok_count, 32'd0);
    checkOutput("rst_errc", err_count, 32'd0);

    for (int i = 0; i < 10; i++) applyStimulus(IDLE_W, 8'hFF);
    checkOutput("idle_state", 32'(state), 32'd0);
    checkOutput("idle_okc", ok_count, 32'd0);
    checkOutput("idle_errc", err_count, 32'd0);

    sendFrame(20, TERM3_W, 8'hF8, 163, "len163");

    applyStimulus(START_W, 8'h01);
    applyStimulus(DATA_W, 8'h00);
    applyStimulus(DATA_W, 8'h00);
    expectPulse(1'b0, 16'd0);
    applyStimulus(IDLE_W, 8'hFF);
    checkOutput("early_idle_state", 32'(state), 32'd2);
    applyStimulus(IDLE_W, 8'hFF);
    checkOutput("err_recover_state", 32'(state), 32'd0);

    sendFrame(8, TERM0_W, 8'hFF, 64, "len64");

    applyStimulus(START_W, 8'h01);
    applyStimulus(DATA_W, 8'h00);
    expectPulse(1'b0, 16'd0);
    applyStimulus(START_W, 8'h01);
    checkOutput("dup_start_state", 32'(state), 32'd2);
    applyStimulus(START_W, 8'h01);
    checkOutput("err_ignores_start", 32'(state), 32'd2);
    applyStimulus(IDLE_W, 8'hFF);
    checkOutput("err_idle_state", 32'(state), 32'd0);
    sendFrame(1, TERM0_W, 8'hFF, 8, "len8");

    expectPulse(1'b0, 16'd0);
    applyStimulus(DATA_W, 8'h00);
    checkOutput("idle_data_state", 32'(state), 32'd2);
    applyStimulus(IDLE_W, 8'hFF);

    applyStimulus(STARTD5, 8'h01);
    applyStimulus(DATA_W, 8'h00);
    expectPulse(lenOk(15), 16'd15);
    applyStimulus(TERM7_W, 8'h80);
    checkOutput("term7_state", 32'(state), 32'd0);

    applyStimulus(START_W, 8'h01);
    applyStimulus(DATA_W, 8'h00);
    expectPulse(1'b0, 16'd0);
    applyStimulus(BADT_W, 8'hF8);
    checkOutput("bad_term_state", 32'(state), 32'd2);
    applyStimulus(IDLE_W, 8'hFF);

    applyStimulus(START_W, 8'h01);
    applyStimulus(DATA_W, 8'h00);
    rst_n = 1'b1;
    applyStimulus(DATA_W, 8'h00);
    rst_n = 1'b0;
    m_okc  = 0;
    m_errc = 0;
    checkOutput("midrst_state", 32'(state), 32'd0);
    checkOutput("midrst_okc", ok_count, 32'd0);
    checkOutput("midrst_errc", err_count, 32'd0);
    applyStimulus(IDLE_W, 8'hFF);
    sendFrame(9, TERM3_W, 8'hF8, 75, "len75");

    applyStimulus(IDLE_W, 8'hFF);
    applyStimulus(IDLE_W, 8'hFF);
    if (sb.size() != 0) checkOutput("pending_pulses", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
